bch_31_decoder: RTL and testbench
=================================

# bch_31_decoder

Sequential BCH(31,21) double-error-correcting decoder, the receive-side partner of `bch_31_encoder`. It accepts one 31-bit codeword per valid/ready handshake and computes syndromes S1 and S3. It then forms a division-free error-locator polynomial and runs a 31-cycle serial Chien search. It returns the corrected 21-bit message with an error count and an uncorrectable flag, using fixed latency and output backpressure.

## Interface
- Parameters: none. Code is fixed: n=31, k=21, t=2, GF(2^5) with primitive p(x)=x^5+x^2+1, generator g(x)=x^10+x^9+x^8+x^6+x^5+x^3+1 (11'h769).
- Reset is asynchronous and active-low, on one clock.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  codeword present.
- in_ready  output  1  decoder idle, can accept.
- codeword  input  31  received word; bit i = coefficient of x^i; [30:10] message, [9:0] parity (systematic, as produced by the encoder).
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- msg  output  21  corrected message (codeword[30:10] after correction).
- err_count  output  2  number of corrected bit errors: 0, 1 or 2; 3 when uncorrectable.
- uncorrectable  output  1  decoding failure; msg is the raw uncorrected codeword[30:10].

## Operation
- FSM states: IDLE, SYND, KEY, CHIEN, DONE.
- IDLE: in_ready=1. When in_valid&in_ready, register codeword → SYND.
- SYND (1 cycle): S1 = XOR of α^i over set bits i; S3 = XOR of α^(3i). Register both → KEY.
- KEY (1 cycle): λ0=S1, λ1=S1², λ2=S3⊕S1³. Classify:
  - S1=0, S3=0 → no error.
  - S1=0, S3≠0 → uncorrectable.
  - λ2=0 → expect 1 root.
  - Otherwise → expect 2 roots.
  - Load Chien registers r1=λ1, r2=λ2, position counter=0 → CHIEN.
- CHIEN (31 cycles, position i=0..30): root if λ0⊕r1⊕r2=0.
  - On a root, flip bit i of the held word and increment the root counter, saturating at 3.
  - Then r1←r1·α^-1 and r2←r2·α^-2.
  - Chien runs in every class, including the no-error and uncorrectable classes. In those two classes no flips are applied.
- End of CHIEN → DONE:
  - If root count ≠ expected, or the class is uncorrectable: uncorrectable=1, err_count=3, msg = original codeword[30:10].
  - Otherwise err_count = root count and msg = corrected[30:10].
  - Parity-bit errors count toward err_count.
- DONE: out_valid=1, outputs stable until out_ready=1. The cycle after the out handshake → IDLE.
- GF multiply: combinational GF(2^5) products reduced by p(x). No dividers.

## Timing
- Reset values (asynchronous, immediate): state IDLE, in_ready=1, out_valid=0, msg=0, err_count=0, uncorrectable=0. Internal registers clear.
- Latency: out_valid rises exactly 34 clock edges after the input-acceptance edge (1 SYND + 1 KEY + 31 CHIEN + 1 to DONE). Latency is fixed and independent of error count.
- in_ready=0 from the cycle after acceptance until back in IDLE. in_valid is ignored in the meantime. There is no pipelining, so throughput is at most 1 word per 35 cycles.
- Input handshake and output handshake never overlap. in_ready rises the cycle after out_valid&out_ready.
- Outputs are registered, and msg/err_count/uncorrectable change only on the DONE-entry edge.
- Reset asserted mid-operation (any state) aborts the word immediately. No partial result is ever presented.
- More than 2 errors may be miscorrected to another codeword. This is not required to be detected; only a root-count mismatch or S1=0/S3≠0 is flagged.

## Test plan
- Clean word 31'h00002F57 (msg 21'h00000B) → msg=21'h00000B, err_count=0, uncorrectable=0, out_valid exactly 34 edges after acceptance.
- Single error, bit 30 flipped: 31'h40002F57 → msg=21'h00000B, err_count=1, uncorrectable=0.
- Double error, bits 0 and 17 flipped: 31'h00022F56 → msg=21'h00000B, err_count=2. Repeat with all-zero codeword plus bits 5 and 29 set → msg=0, err_count=2.
- Sweep all 31 single-error and all 465 double-error patterns on codeword 31'h00002F57 → every result msg=21'h00000B with the correct err_count.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, driving in_valid=1 → msg/err_count stable, in_ready=0, no second word accepted. out_ready=1 → in_ready=1 next cycle.
- Pull rst_n low during CHIEN (cycle 15 after acceptance) → out_valid=0, in_ready=1, msg=0 immediately. A following clean word decodes correctly with 34-edge latency.

Source files
------------

// File: rtl/bch_31_decoder.sv
// BCH(31,21) t=2 decoder over GF(2^5), p(x)=x^5+x^2+1.
// Computes the syndromes, builds a division-free locator, runs a serial Chien search, then presents a registered result.
module bch_31_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] codeword,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] msg,
  output logic [1:0]  err_count,
  output logic        uncorrectable
);

  typedef enum logic [2:0] {IDLE, SYND, KEY, CHIEN, DONE} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_TWO, CLS_FAIL} cls_t;

  localparam logic [4:0] ALPHA      = 5'h02;
  localparam logic [4:0] ALPHA3     = 5'h08;
  localparam logic [4:0] ALPHA_INV  = 5'h12;
  localparam logic [4:0] ALPHA_INV2 = 5'h09;

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] acc;
    logic [4:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 5; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[3:0], 1'b0} ^ (x[4] ? 5'h05 : 5'h00);
    end
    return acc;
  endfunction

  // step = alpha for S1, alpha^3 for S3
  function automatic logic [4:0] syndrome(input logic [30:0] w, input logic [4:0] step);
    logic [4:0] acc;
    logic [4:0] pw;
    acc = '0;
    pw  = 5'h01;
    for (int unsigned i = 0; i < 31; i++) begin
      if (w[i]) acc = acc ^ pw;
      pw = gf_mul(pw, step);
    end
    return acc;
  endfunction

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [30:0] word_q, word_d;
  logic [30:0] flip_q, flip_d;
  logic [4:0]  s1_q, s1_d;
  logic [4:0]  s3_q, s3_d;
  logic [4:0]  r1_q, r1_d;
  logic [4:0]  r2_q, r2_d;
  logic [4:0]  pos_q, pos_d;
  logic [1:0]  roots_q, roots_d;
  logic [20:0] msg_q, msg_d;
  logic [1:0]  err_q, err_d;
  logic        unc_q, unc_d;

  logic [4:0]  s1_sq, s1_cube, lam2;
  logic [1:0]  exp_roots;
  logic        is_root;

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign msg           = msg_q;
  assign err_count     = err_q;
  assign uncorrectable = unc_q;

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    word_d  = word_q;
    flip_d  = flip_q;
    s1_d    = s1_q;
    s3_d    = s3_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    pos_d   = pos_q;
    roots_d = roots_q;
    msg_d   = msg_q;
    err_d   = err_q;
    unc_d   = unc_q;

    s1_sq     = gf_mul(s1_q, s1_q);
    s1_cube   = gf_mul(s1_sq, s1_q);
    lam2      = s3_q ^ s1_cube;
    // lambda0 is S1 itself, so s1_q doubles as the constant Chien term
    is_root   = ((s1_q ^ r1_q ^ r2_q) == 5'h00);
    exp_roots = (cls_q == CLS_TWO) ? 2'd2 : ((cls_q == CLS_ONE) ? 2'd1 : 2'd0);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = codeword;
          flip_d  = '0;
          state_d = SYND;
        end
      end
      SYND: begin
        s1_d    = syndrome(word_q, ALPHA);
        s3_d    = syndrome(word_q, ALPHA3);
        state_d = KEY;
      end
      KEY: begin
        if (s1_q == 5'h00) cls_d = (s3_q == 5'h00) ? CLS_NONE : CLS_FAIL;
        else if (lam2 == 5'h00) cls_d = CLS_ONE;
        else cls_d = CLS_TWO;
        r1_d    = s1_sq;
        r2_d    = lam2;
        pos_d   = '0;
        roots_d = '0;
        state_d = CHIEN;
      end
      CHIEN: begin
        // Positions 0..30 are searched; pos 31 is the extra cycle that commits the result.
        if (pos_q == 5'd31) begin
          if (cls_q == CLS_FAIL || roots_q != exp_roots) begin
            unc_d = 1'b1;
            err_d = 2'd3;
            msg_d = word_q[30:10];
          end else begin
            unc_d = 1'b0;
            err_d = roots_q;
            msg_d = word_q[30:10] ^ flip_q[30:10];
          end
          state_d = DONE;
        end else begin
          if (is_root && (cls_q == CLS_ONE || cls_q == CLS_TWO)) begin
            flip_d  = flip_q | (31'd1 << pos_q);
            roots_d = (roots_q == 2'd3) ? 2'd3 : roots_q + 2'd1;
          end
          r1_d  = gf_mul(r1_q, ALPHA_INV);
          r2_d  = gf_mul(r2_q, ALPHA_INV2);
          pos_d = pos_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cls_q   <= CLS_NONE;
      word_q  <= '0;
      flip_q  <= '0;
      s1_q    <= '0;
      s3_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      pos_q   <= '0;
      roots_q <= '0;
      msg_q   <= '0;
      err_q   <= '0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      word_q  <= word_d;
      flip_q  <= flip_d;
      s1_q    <= s1_d;
      s3_q    <= s3_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      pos_q   <= pos_d;
      roots_q <= roots_d;
      msg_q   <= msg_d;
      err_q   <= err_d;
      unc_q   <= unc_d;
    end
  end

endmodule

// File: tb/tb_bch_31_decoder.sv
// Bench for bch_31_decoder: directed table, exhaustive 1/2-error sweep, random words checked
// against a brute-force nearest-codeword model, plus backpressure and mid-search reset sequences.
module tb_bch_31_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] codeword;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] msg;
  logic [1:0]  err_count;
  logic        uncorrectable;

  int n_vec;
  int n_bad;

  localparam logic [30:0] BASE = 31'h00002F57;

  bch_31_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .codeword      (codeword),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .msg           (msg),
    .err_count     (err_count),
    .uncorrectable (uncorrectable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] cw;
    logic [20:0] msg;
    logic [1:0]  err;
    logic        unc;
  } vec_t;

  // Remainder of w(x) mod g(x); zero means w is a codeword.
  function automatic logic [9:0] rem_g(input logic [30:0] w);
    logic [30:0] x;
    logic [30:0] g;
    x = w;
    g = 31'h769;
    for (int i = 30; i >= 10; i--)
      if (x[i]) x = x ^ (g << (i - 10));
    return x[9:0];
  endfunction

  // Unique codeword within Hamming distance 2, else flagged as uncorrectable.
  task automatic ref_decode(input logic [30:0] r, output logic [20:0] m,
                            output logic [1:0] e, output logic u);
    logic found;
    logic [30:0] t;
    found = 1'b0;
    m = r[30:10];
    e = 2'd3;
    u = 1'b1;
    if (rem_g(r) == 10'd0) begin
      found = 1'b1; m = r[30:10]; e = 2'd0; u = 1'b0;
    end
    for (int a = 0; a < 31 && !found; a++) begin
      t = r ^ (31'd1 << a);
      if (rem_g(t) == 10'd0) begin
        found = 1'b1; m = t[30:10]; e = 2'd1; u = 1'b0;
      end
    end
    for (int a = 0; a < 31 && !found; a++)
      for (int b = a + 1; b < 31 && !found; b++) begin
        t = r ^ (31'd1 << a) ^ (31'd1 << b);
        if (rem_g(t) == 10'd0) begin
          found = 1'b1; m = t[30:10]; e = 2'd2; u = 1'b0;
        end
      end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic run_word(input string tag, input logic [30:0] cw, input logic [20:0] em,
                          input logic [1:0] ee, input logic eu);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    codeword = cw;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    codeword = 31'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 100);
    check({tag, " latency"}, 32'(lat), 32'd34);
    check({tag, " msg"}, 32'(msg), 32'(em));
    check({tag, " err_count"}, 32'(err_count), 32'(ee));
    check({tag, " uncorrectable"}, 32'(uncorrectable), 32'(eu));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t tbl [7];
    logic [20:0] rm;
    logic [1:0]  re;
    logic        ru;
    logic [30:0] cw;
    logic [30:0] rx;
    logic [20:0] m;
    int lat;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    codeword = '0;

    tbl[0] = '{31'h00002F57, 21'h00000B, 2'd0, 1'b0};
    tbl[1] = '{31'h40002F57, 21'h00000B, 2'd1, 1'b0};
    tbl[2] = '{31'h00022F56, 21'h00000B, 2'd2, 1'b0};
    tbl[3] = '{31'h20000020, 21'h000000, 2'd2, 1'b0};
    tbl[4] = '{31'h00000000, 21'h000000, 2'd0, 1'b0};
    tbl[5] = '{31'h7FFFEFFF, 21'h1FFFFF, 2'd1, 1'b0};
    tbl[6] = '{31'h00002F57, 21'h00000B, 2'd0, 1'b0};

    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset msg", 32'(msg), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset uncorrectable", 32'(uncorrectable), 32'd0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_word($sformatf("table%0d", i), tbl[i].cw, tbl[i].msg, tbl[i].err, tbl[i].unc);

    // Reset in the middle of the Chien search; the last table entry left msg=0xB.
    codeword = BASE ^ 31'h00000100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset msg", 32'(msg), 32'd0);
    check("midreset err_count", 32'(err_count), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("postreset no output", 32'(out_valid), 32'd0);
    end
    run_word("postreset clean", BASE, 21'h00000B, 2'd0, 1'b0);

    // Backpressure with a competing input held valid.
    codeword = BASE ^ 31'h00000008;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 100);
    check("bp latency", 32'(lat), 32'd34);
    in_valid = 1'b1;
    codeword = 31'h12345678;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp in_ready low", 32'(in_ready), 32'd0);
      check("bp msg stable", 32'(msg), 32'h00000B);
      check("bp err stable", 32'(err_count), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp in_ready after handshake", 32'(in_ready), 32'd1);
    check("bp out_valid after handshake", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp no extra accept", 32'(in_ready), 32'd1);

    // Exhaustive single and double errors on the reference word.
    for (int a = 0; a < 31; a++)
      run_word($sformatf("single%0d", a), BASE ^ (31'd1 << a), 21'h00000B, 2'd1, 1'b0);
    for (int a = 0; a < 31; a++)
      for (int b = a + 1; b < 31; b++)
        run_word($sformatf("double%0d_%0d", a, b),
                 BASE ^ (31'd1 << a) ^ (31'd1 << b), 21'h00000B, 2'd2, 1'b0);

    // Random messages with 0..4 random bit flips against the brute-force model.
    for (int n = 0; n < 150; n++) begin
      m  = 21'($urandom);
      cw = {m, rem_g({m, 10'd0})};
      rx = cw;
      for (int k = 0, ne = $urandom_range(0, 4); k < ne; k++)
        rx = rx ^ (31'd1 << $urandom_range(0, 30));
      ref_decode(rx, rm, re, ru);
      run_word($sformatf("rand%0d", n), rx, rm, re, ru);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
